// File: rtl/figo_seq_tx.sv
// ---------------------------------------------------------------------------
// figo_seq_tx -- serial pattern transmitter
//
// Loads a bit pattern on a start pulse and shifts it out MSB-first, one bit
// per clock. The pattern can be repeated with idle gaps between repetitions.
// A one-cycle done pulse marks completion. This block is the stimulus source
// and in-system sequence generator that feeds the figo_fsm detector input.
//
// Optional feature: define FIGO_TX_PARITY_EN to append one even-parity bit
// after bit 0 of every repetition.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   start       start request, sampled only while idle
//   pat_data    pattern; bit pat_len-1 is sent first, bit 0 is sent last
//   pat_len     pattern length, accepted range 1..PAT_MAX
//   repeat_cnt  extra repetitions (total transmissions = repeat_cnt + 1)
//   outbit      serial data to the detector (registered)
//   bit_valid   outbit carries a pattern or parity bit
//   busy        transfer in progress (send and gap cycles)
//   done        one-cycle completion pulse
// ---------------------------------------------------------------------------
module figo_seq_tx #(
    parameter int   PAT_MAX    = 8,
    parameter int   LEN_W      = 4,
    parameter int   GAP_CYCLES = 2,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [PAT_MAX-1:0] pat_data,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic [3:0]         repeat_cnt,
    output logic               outbit,
    output logic               bit_valid,
    output logic               busy,
    output logic               done
);

    localparam int IDX_W = (PAT_MAX > 1) ? $clog2(PAT_MAX) : 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

`ifdef FIGO_TX_PARITY_EN
    // Even parity over the low len bits of pat (the bits actually transmitted).
    function automatic logic even_parity(input logic [PAT_MAX-1:0] pat,
                                         input logic [LEN_W-1:0]   len);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < PAT_MAX; i++) begin
            if (i < int'(len)) begin
                acc = acc ^ pat[i];
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction
`endif

    state_t             state_r, state_s;
    logic [PAT_MAX-1:0] pat_r, pat_s;
    logic [IDX_W-1:0]   top_idx_r, top_idx_s;
    logic [IDX_W-1:0]   idx_r, idx_s;
    logic [3:0]         reps_r, reps_s;
    logic [GAP_W-1:0]   gap_r, gap_s;
    logic               outbit_r, outbit_s;
    logic               bit_valid_r, bit_valid_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic               rep_end_s;
    logic               len_ok_s;
    logic [IDX_W-1:0]   first_idx_s;
`ifdef FIGO_TX_PARITY_EN
    logic               par_r, par_s;
    logic               par_phase_r, par_phase_s;
`endif

    assign len_ok_s    = (pat_len != {LEN_W{1'b0}}) && (pat_len <= LEN_W'(PAT_MAX));
    assign first_idx_s = IDX_W'(pat_len - LEN_W'(1));

    // Next-state and next-output logic; outputs default to the idle level.
    always_comb begin
        state_s     = state_r;
        pat_s       = pat_r;
        top_idx_s   = top_idx_r;
        idx_s       = idx_r;
        reps_s      = reps_r;
        gap_s       = gap_r;
        outbit_s    = IDLE_LEVEL;
        bit_valid_s = 1'b0;
        busy_s      = 1'b0;
        done_s      = 1'b0;
        rep_end_s   = 1'b0;
`ifdef FIGO_TX_PARITY_EN
        par_s       = par_r;
        par_phase_s = par_phase_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start && len_ok_s) begin
                    state_s     = ST_SEND;
                    pat_s       = pat_data;
                    top_idx_s   = first_idx_s;
                    idx_s       = first_idx_s;
                    reps_s      = repeat_cnt;
                    outbit_s    = pat_data[first_idx_s];
                    bit_valid_s = 1'b1;
                    busy_s      = 1'b1;
`ifdef FIGO_TX_PARITY_EN
                    par_s       = even_parity(pat_data, pat_len);
                    par_phase_s = 1'b0;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                busy_s = 1'b1;
`ifdef FIGO_TX_PARITY_EN
                if (par_phase_r) begin
                    rep_end_s = 1'b1;
                end else if (idx_r == IDX_W'(0)) begin
                    par_phase_s = 1'b1;
                    outbit_s    = par_r;
                    bit_valid_s = 1'b1;
                end else begin
                    idx_s       = idx_r - IDX_W'(1);
                    outbit_s    = pat_r[idx_r - IDX_W'(1)];
                    bit_valid_s = 1'b1;
                end
`else
                if (idx_r == IDX_W'(0)) begin
                    rep_end_s = 1'b1;
                end else begin
                    idx_s       = idx_r - IDX_W'(1);
                    outbit_s    = pat_r[idx_r - IDX_W'(1)];
                    bit_valid_s = 1'b1;
                end
`endif
                if (rep_end_s) begin
`ifdef FIGO_TX_PARITY_EN
                    par_phase_s = 1'b0;
`endif
                    if (reps_r != 4'd0) begin
                        reps_s = reps_r - 4'd1;
                        if (GAP_CYCLES == 0) begin
                            // Back-to-back: next repetition starts immediately.
                            state_s     = ST_SEND;
                            idx_s       = top_idx_r;
                            outbit_s    = pat_r[top_idx_r];
                            bit_valid_s = 1'b1;
                        end else begin
                            state_s = ST_GAP;
                            gap_s   = GAP_W'(GAP_CYCLES - 1);
                        end
                    end else begin
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                        busy_s  = 1'b0;
                    end
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_GAP: begin
                busy_s = 1'b1;
                if (gap_r == GAP_W'(0)) begin
                    state_s     = ST_SEND;
                    idx_s       = top_idx_r;
                    outbit_s    = pat_r[top_idx_r];
                    bit_valid_s = 1'b1;
                end else begin
                    gap_s = gap_r - GAP_W'(1);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; reset wins over any request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            pat_r       <= {PAT_MAX{1'b0}};
            top_idx_r   <= {IDX_W{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            reps_r      <= 4'd0;
            gap_r       <= {GAP_W{1'b0}};
            outbit_r    <= IDLE_LEVEL;
            bit_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
`ifdef FIGO_TX_PARITY_EN
            par_r       <= 1'b0;
            par_phase_r <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            pat_r       <= pat_s;
            top_idx_r   <= top_idx_s;
            idx_r       <= idx_s;
            reps_r      <= reps_s;
            gap_r       <= gap_s;
            outbit_r    <= outbit_s;
            bit_valid_r <= bit_valid_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
`ifdef FIGO_TX_PARITY_EN
            par_r       <= par_s;
            par_phase_r <= par_phase_s;
`endif
        end
    end

    assign outbit    = outbit_r;
    assign bit_valid = bit_valid_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_figo_seq_tx.sv
// ---------------------------------------------------------------------------
// tb_figo_seq_tx -- self-checking bench for figo_seq_tx
//
// Expected per-cycle output vectors {outbit, bit_valid, busy, done} are
// queued as stimulus is applied and compared one per clock, #1 after the
// rising edge. Parity expectations follow FIGO_TX_PARITY_EN.
// ---------------------------------------------------------------------------
module tb_figo_seq_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] pat_data;
    logic [3:0] pat_len;
    logic [3:0] repeat_cnt;
    logic       outbit;
    logic       bit_valid;
    logic       busy;
    logic       done;

    logic [3:0] exp_q[$];
    int         total = 0;
    int         bad   = 0;

    figo_seq_tx #(
        .PAT_MAX   (8),
        .LEN_W     (4),
        .GAP_CYCLES(2),
        .IDLE_LEVEL(1'b0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pat_data  (pat_data),
        .pat_len   (pat_len),
        .repeat_cnt(repeat_cnt),
        .outbit    (outbit),
        .bit_valid (bit_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic push(input logic ob, input logic bv, input logic bz, input logic dn);
        exp_q.push_back({ob, bv, bz, dn});
    endtask

    // One transmission of pat[len-1:0], MSB first, plus parity when enabled.
    task automatic push_rep(input logic [7:0] pat, input int len);
        logic p;
        p = 1'b0;
        for (int i = len - 1; i >= 0; i--) begin
            push(pat[i], 1'b1, 1'b1, 1'b0);
            p = p ^ pat[i];
        end
`ifdef FIGO_TX_PARITY_EN
        push(p, 1'b1, 1'b1, 1'b0);
`endif
    endtask

    task automatic push_gap();
        repeat (2) push(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic push_done();
        push(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic push_idle(input int n);
        repeat (n) push(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step_check(input string tag);
        logic [3:0] obs;
        logic [3:0] exp;
        @(posedge clk);
        #1;
        obs = {outbit, bit_valid, busy, done};
        if (exp_q.size() == 0) begin
            exp = 4'bxxxx;
        end else begin
            exp = exp_q.pop_front();
        end
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed {out,valid,busy,done}=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) begin
            step_check(tag);
        end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        pat_data   = 8'h00;
        pat_len    = 4'd0;
        repeat_cnt = 4'd0;

        // Reset held for two cycles.
        push_idle(2);
        drain("reset");
        reset = 1'b0;

        // Single transmission of 1101.
        pat_data = 8'h0D; pat_len = 4'd4; repeat_cnt = 4'd0; start = 1'b1;
        push_rep(8'h0D, 4); push_done(); push_idle(1);
        step_check("single");
        start = 1'b0;
        drain("single");

        // Two transmissions of 110 with a two-cycle gap.
        pat_data = 8'h06; pat_len = 4'd3; repeat_cnt = 4'd1; start = 1'b1;
        push_rep(8'h06, 3); push_gap(); push_rep(8'h06, 3); push_done(); push_idle(1);
        step_check("repeat1");
        start = 1'b0;
        drain("repeat1");

        // Start and input changes while busy are ignored.
        pat_data = 8'h0D; pat_len = 4'd4; repeat_cnt = 4'd0; start = 1'b1;
        push_rep(8'h0D, 4); push_done(); push_idle(2);
        step_check("busy_start");
        start = 1'b0;
        step_check("busy_start");
        pat_data = 8'hFF; pat_len = 4'd8; repeat_cnt = 4'd3; start = 1'b1;
        step_check("busy_start");
        start = 1'b0;
        drain("busy_start");

        // Illegal lengths are ignored in idle.
        pat_data = 8'hFF; pat_len = 4'd0; repeat_cnt = 4'd0; start = 1'b1;
        push_idle(3);
        drain("len0");
        pat_len = 4'd9;
        push_idle(3);
        drain("len9");
        start = 1'b0;
        push_idle(1);
        drain("len9");

        // Full-width pattern.
        pat_data = 8'hA5; pat_len = 4'd8; repeat_cnt = 4'd0; start = 1'b1;
        push_rep(8'hA5, 8); push_done(); push_idle(1);
        step_check("len8");
        start = 1'b0;
        drain("len8");

        // Maximum repeat count gives sixteen transmissions.
        pat_data = 8'h01; pat_len = 4'd1; repeat_cnt = 4'd15; start = 1'b1;
        for (int r = 0; r < 16; r++) begin
            push_rep(8'h01, 1);
            if (r < 15) begin
                push_gap();
            end
        end
        push_done(); push_idle(1);
        step_check("rep15");
        start = 1'b0;
        drain("rep15");

        // Reset in the middle of a transmission: no done pulse afterwards.
        pat_data = 8'h0D; pat_len = 4'd4; repeat_cnt = 4'd0; start = 1'b1;
        push(1'b1, 1'b1, 1'b1, 1'b0);
        push(1'b1, 1'b1, 1'b1, 1'b0);
        push_idle(5);
        step_check("mid_reset");
        start = 1'b0;
        step_check("mid_reset");
        reset = 1'b1;
        step_check("mid_reset");
        reset = 1'b0;
        drain("mid_reset");

        // Reset and start together: reset wins.
        pat_data = 8'h0D; pat_len = 4'd4; repeat_cnt = 4'd0;
        reset = 1'b1; start = 1'b1;
        push_idle(1);
        step_check("reset_start");
        reset = 1'b0; start = 1'b0;
        push_idle(2);
        drain("reset_start");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
